bam_product_accumulator: RTL and testbench

Sequential dot-product stage that sits directly downstream of the 8x8 unsigned approximate broken-array multipliers. It consumes one 16-bit product per handshake, adds a per-product bias constant that compensates the multiplier's truncation error, and accumulates a programmed number of products. It then presents the sum on a valid/ready output port. It turns the combinational approximate multiplier into an approximate MAC usable by the accelerator datapaths and the error-evaluation benches.

---
 rtl/bam_product_accumulator.sv | 101 ++++++++++
 tb/tb_bam_product_accumulator.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bam_product_accumulator.sv
// Approximate-MAC back end: accumulates a programmed number of biased products
// from the broken-array multiplier and returns the sum over a valid/ready port.
module bam_product_accumulator #(
  parameter int unsigned       PROD_W = 16,
  parameter int unsigned       ACC_W  = 24,
  parameter int unsigned       LEN_W  = 8,
  parameter logic [PROD_W-1:0] BIAS   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  // Two guard bits: acc + product + bias can exceed 2^(ACC_W+1) when ACC_W == PROD_W.
  localparam int unsigned SUM_W = ACC_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc_nxt;
  logic              ovf_nxt;
  logic [LEN_W-1:0]  cnt, cnt_nxt;
  logic [SUM_W-1:0]  sum;

  assign sum = SUM_W'(out_acc) + SUM_W'(in_prod) + SUM_W'(BIAS);

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    acc_nxt   = out_acc;
    ovf_nxt   = out_ovf;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          if (len != '0) begin
            cnt_nxt   = len;
            state_nxt = ACC;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_nxt = sum[ACC_W-1:0];
          if (|sum[SUM_W-1:ACC_W]) begin
            ovf_nxt = 1'b1;
          end
          cnt_nxt = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_acc   <= acc_nxt;
      out_ovf   <= ovf_nxt;
      cnt       <= cnt_nxt;
      in_ready  <= (state_nxt == ACC);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_bam_product_accumulator.sv
// Directed bench for bam_product_accumulator: three instances (default, biased,
// 16-bit accumulator) share one stimulus stream and are checked against hand values.
module tb_bam_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_ovf, a_busy;
  logic [23:0] a_out_acc;
  logic        b_in_ready, b_out_valid, b_out_ovf, b_busy;
  logic [23:0] b_out_acc;
  logic        c_in_ready, c_out_valid, c_out_ovf, c_busy;
  logic [15:0] c_out_acc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bam_product_accumulator u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_prod(in_prod),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_acc(a_out_acc),
    .out_ovf(a_out_ovf), .busy(a_busy)
  );

  bam_product_accumulator #(.BIAS(16'h0080)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_prod(in_prod),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_acc(b_out_acc),
    .out_ovf(b_out_ovf), .busy(b_busy)
  );

  bam_product_accumulator #(.ACC_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_prod(in_prod),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_acc(c_out_acc),
    .out_ovf(c_out_ovf), .busy(c_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
    len   = 8'd0;
  endtask

  task automatic beat(input logic [15:0] p);
    in_valid = 1'b1;
    in_prod  = p;
    tick();
    in_valid = 1'b0;
    in_prod  = 16'h0000;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 8'd0;
    in_valid = 1'b0; in_prod = 16'h0; out_ready = 1'b0;
    #12;
    chk("reset_flags", {31'd0, a_in_ready | a_out_valid | a_busy | a_out_ovf}, 32'd0);
    chk("reset_acc", {8'd0, a_out_acc}, 32'd0);
    #5 rst_n = 1'b1;
    tick();

    // Basic run, back-to-back products
    do_start(8'd3);
    chk("start_in_ready", {30'd0, a_in_ready, a_busy}, 32'd3);
    beat(16'h0100);
    beat(16'h3F00);
    chk("basic_not_done", {31'd0, a_out_valid}, 32'd0);
    beat(16'h7F00);
    chk("basic_valid", {30'd0, a_out_valid, a_in_ready}, 32'd2);
    chk("basic_acc", {8'd0, a_out_acc}, 32'h00BF00);
    chk("basic_ovf", {31'd0, a_out_ovf}, 32'd0);
    chk("basic_bias_acc", {8'd0, b_out_acc}, 32'h00C080);
    release_result();
    chk("basic_idle", {30'd0, a_out_valid, a_busy}, 32'd0);

    // Bias compensation
    do_start(8'd2);
    beat(16'h0100);
    beat(16'h0100);
    chk("bias_acc", {8'd0, b_out_acc}, 32'h000300);
    chk("nobias_acc", {8'd0, a_out_acc}, 32'h000200);
    release_result();

    // Overflow on the 16-bit accumulator, then cleared by the next run
    do_start(8'd2);
    beat(16'hFFFF);
    beat(16'h0002);
    chk("ovf_acc", {16'd0, c_out_acc}, 32'h0001);
    chk("ovf_flag", {31'd0, c_out_ovf}, 32'd1);
    chk("wide_no_ovf", {7'd0, a_out_ovf, a_out_acc}, 32'h0010001);
    release_result();
    do_start(8'd1);
    beat(16'h0005);
    chk("ovf_clear", {15'd0, c_out_ovf, c_out_acc}, 32'h00005);
    release_result();

    // Zero length goes straight to DONE
    do_start(8'd0);
    chk("zero_len", {6'd0, a_out_valid, a_in_ready, a_out_acc}, 32'h2000000);
    release_result();

    // Start pulsed during ACC is ignored
    do_start(8'd2);
    beat(16'h0010);
    do_start(8'd5);
    chk("ign_start_acc", {30'd0, a_in_ready, a_out_valid}, 32'd2);
    beat(16'h0020);
    chk("ign_start_result", {7'd0, a_out_valid, a_out_acc}, 32'h1000030);
    // Start during DONE is dropped, not queued
    start = 1'b1; len = 8'd4; out_ready = 1'b1;
    tick();
    start = 1'b0; len = 8'd0; out_ready = 1'b0;
    tick();
    chk("done_start_dropped", {30'd0, a_busy, a_in_ready}, 32'd0);

    // Input stalls: garbage on invalid cycles must not be accepted
    do_start(8'd3);
    beat(16'h0011);
    in_prod = 16'hFFFF; tick();
    beat(16'h0022);
    in_prod = 16'hFFFF; tick();
    chk("stall_not_done", {31'd0, a_out_valid}, 32'd0);
    beat(16'h0033);
    chk("stall_acc", {7'd0, a_out_valid, a_out_acc}, 32'h1000066);
    // Output backpressure holds everything
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_prod = 16'h1111; start = 1'b1;
      tick();
      chk("hold", {7'd0, a_out_valid, a_out_acc}, 32'h1000066);
    end
    in_valid = 1'b0; in_prod = 16'h0; start = 1'b0;
    release_result();
    chk("release_idle", {30'd0, a_out_valid, a_busy}, 32'd0);

    // Reset in the middle of a run
    do_start(8'd4);
    beat(16'h0100);
    beat(16'h0200);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_flags", {28'd0, a_in_ready, a_out_valid, a_busy, a_out_ovf}, 32'd0);
    chk("midrst_acc", {8'd0, a_out_acc}, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    do_start(8'd1);
    beat(16'h1234);
    chk("post_rst_acc", {7'd0, a_out_valid, a_out_acc}, 32'h1001234);
    release_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
